// File: rtl/output_collector_pkg.sv
// Shared types for the output collector: FSM states and the buffered pixel record.
package output_collector_pkg;

    localparam int ACC_W   = 32;
    localparam int COORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FLUSH
    } collector_state_t;

    typedef struct packed {
        logic [ACC_W-1:0]   data;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] ch;
    } output_entry_t;

endpackage

// File: rtl/output_collector_if.sv
// Pixel stream between the conv controller, the collector and the host.
// slave = collector side, master = controller/host side.
interface output_collector_if #(
    parameter int ACC_WIDTH   = 32,
    parameter int COORD_WIDTH = 32
);
    logic                   in_valid;
    logic [ACC_WIDTH-1:0]   in_data;
    logic [COORD_WIDTH-1:0] in_x;
    logic [COORD_WIDTH-1:0] in_y;
    logic [COORD_WIDTH-1:0] in_ch;
    logic                   stall;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   out_data;
    logic [COORD_WIDTH-1:0] out_x;
    logic [COORD_WIDTH-1:0] out_y;
    logic [COORD_WIDTH-1:0] out_ch;

    modport slave (
        input  in_valid, in_data, in_x, in_y, in_ch, out_ready,
        output stall, out_valid, out_data, out_x, out_y, out_ch
    );

    modport master (
        output in_valid, in_data, in_x, in_y, in_ch, out_ready,
        input  stall, out_valid, out_data, out_x, out_y, out_ch
    );
endinterface

// File: rtl/output_fifo.sv
// Generic show-ahead FIFO with a registered head; clr empties it but keeps the last head value.
// Latency: push at edge N is at the head in cycle N+1 when empty.
// Backpressure: push while full is ignored unless a pop happens on the same edge.
module output_fifo #(
    parameter int  DEPTH = 8,
    parameter type T     = logic [7:0]
) (
    input  logic                   clk,
    input  logic                   arst_n_in,
    input  logic                   clr,
    input  logic                   push,
    input  logic                   pop,
    input  T                       wdat,
    output T                       rdat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    T                 mem [DEPTH];
    T                 head_q;
    logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
    logic [LVL_W-1:0] cnt, remain;
    logic             do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_nxt  = rd_ptr + PTR_W'(do_pop);
    assign remain  = cnt - LVL_W'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr] <= wdat;
    end

    // Head is a separate register so it can be reset and held while empty.
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head_q <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            rd_ptr <= rd_nxt;
            cnt    <= remain + LVL_W'(do_push);
            if (do_push || do_pop) begin
                if (remain != '0)  head_q <= mem[rd_nxt];
                else if (do_push)  head_q <= wdat;
            end
        end
    end

    assign rdat  = head_q;
    assign level = cnt;
endmodule

// File: rtl/output_collector.sv
// Collects finished output pixels per frame into a FIFO and drains them to the host.
// Latency: one cycle in->out when empty. Backpressure: out_ready stalls the head; stall at DEPTH-2.
// OUTPUT_COLLECTOR_RELU_EN: negative data clamped to zero at push.
module output_collector
    import output_collector_pkg::*;
#(
    parameter int ACC_WIDTH     = ACC_W,
    parameter int COORD_WIDTH   = COORD_W,
    parameter int DEPTH         = 8,
    parameter int TOTAL_OUTPUTS = 1024*1024*64
) (
    input  logic                   clk,
    input  logic                   arst_n_in,
    input  logic                   start,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level,
    output_collector_if.slave      bus
);
    localparam int          LVL_W = $clog2(DEPTH) + 1;
    localparam logic [63:0] TOTAL = 64'(TOTAL_OUTPUTS);

    collector_state_t state_q, state_d;
    logic             frame_done_q, frame_done_d;
    logic [63:0]      acc_cnt, drn_cnt;
    logic             clr, push, pop, drop, fifo_full, fifo_empty;
    output_entry_t    wr_entry, head;

    assign clr  = (state_q == IDLE) && start;
    assign push = (state_q == COLLECT) && bus.in_valid;
    assign pop  = bus.out_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        wr_entry.data = bus.in_data[ACC_WIDTH-1:0];
`ifdef OUTPUT_COLLECTOR_RELU_EN
        if (bus.in_data[ACC_WIDTH-1]) wr_entry.data = '0;
`endif
        wr_entry.x  = bus.in_x[COORD_WIDTH-1:0];
        wr_entry.y  = bus.in_y[COORD_WIDTH-1:0];
        wr_entry.ch = bus.in_ch[COORD_WIDTH-1:0];
    end

    output_fifo #(
        .DEPTH (DEPTH),
        .T     (output_entry_t)
    ) u_fifo (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .clr       (clr),
        .push      (push),
        .pop       (pop),
        .wdat      (wr_entry),
        .rdat      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    // A dropped entry counts as drained so a lossy frame still terminates.
    always_comb begin
        state_d      = state_q;
        frame_done_d = 1'b0;
        unique case (state_q)
            IDLE:    if (start) state_d = COLLECT;
            COLLECT: if (push && (acc_cnt + 64'd1 == TOTAL)) state_d = FLUSH;
            FLUSH: begin
                if ((pop || drop) && (drn_cnt + 64'd1 == TOTAL)) begin
                    state_d      = IDLE;
                    frame_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            acc_cnt  <= '0;
            drn_cnt  <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            acc_cnt  <= '0;
            drn_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) acc_cnt <= acc_cnt + 64'd1;
            if ((state_q != IDLE) && (pop || drop)) drn_cnt <= drn_cnt + 64'd1;
            if (drop) overflow <= 1'b1;
        end
    end

    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;
    assign bus.stall     = (level >= LVL_W'(DEPTH - 2));
    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = head.data;
    assign bus.out_x     = head.x;
    assign bus.out_y     = head.y;
    assign bus.out_ch    = head.ch;
endmodule

// File: tb/tb_output_collector.sv
// Bench for output_collector: vector table for backpressure/flush, directed corner
// sequences, then randomized traffic against a queue-based reference model.
module tb_output_collector;
    localparam int DEPTH = 8;
    localparam int TOTAL = 12;

    logic       clk = 1'b0;
    logic       arst_n_in;
    logic       start;
    logic       busy, frame_done, overflow;
    logic [3:0] level;

    output_collector_if #(.ACC_WIDTH(32), .COORD_WIDTH(32)) bus ();

    output_collector #(
        .ACC_WIDTH     (32),
        .COORD_WIDTH   (32),
        .DEPTH         (DEPTH),
        .TOTAL_OUTPUTS (TOTAL)
    ) dut (
        .clk        (clk),
        .arst_n_in  (arst_n_in),
        .start      (start),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow),
        .level      (level),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d, x, y, ch;
    } ent_t;

    typedef struct {
        bit          st, iv, rdy;
        logic [31:0] d;
        int          lvl;
        bit          vld;
        logic [31:0] hd;
        bit          stl, ovf, bsy, fd;
    } vec_t;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: frame phase, a plain queue and per-frame tallies.
    localparam int PH_IDLE = 0, PH_COLLECT = 1, PH_FLUSH = 2;
    ent_t mq[$];
    ent_t m_head;
    int   m_phase, m_acc, m_drn;
    bit   m_ovf, m_fd;

    function automatic logic [31:0] relu_exp(input logic [31:0] v);
`ifdef OUTPUT_COLLECTOR_RELU_EN
        return v[31] ? 32'd0 : v;
`else
        return v;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t mk(input logic [31:0] d);
        ent_t e;
        e.d  = d;
        e.x  = $urandom;
        e.y  = $urandom;
        e.ch = $urandom;
        return e;
    endfunction

    function automatic vec_t v(input bit st, iv, input logic [31:0] d, input bit rdy,
                               input int lvl, input bit vld, input logic [31:0] hd,
                               input bit stl, ovf, bsy, fd);
        vec_t r;
        r.st = st; r.iv = iv; r.d = d; r.rdy = rdy;
        r.lvl = lvl; r.vld = vld; r.hd = hd; r.stl = stl; r.ovf = ovf; r.bsy = bsy; r.fd = fd;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_head  = '{default: '0};
        m_phase = PH_IDLE;
        m_acc   = 0;
        m_drn   = 0;
        m_ovf   = 1'b0;
        m_fd    = 1'b0;
    endtask

    task automatic model_step(input bit st, iv, input ent_t e, input bit rdy);
        int   prev;
        ent_t w;
        prev = m_phase;
        m_fd = 1'b0;
        if (prev == PH_IDLE && st) begin
            mq.delete();
            m_acc   = 0;
            m_drn   = 0;
            m_ovf   = 1'b0;
            m_phase = PH_COLLECT;
        end else begin
            if (rdy && mq.size() > 0) begin
                void'(mq.pop_front());
                if (prev != PH_IDLE) m_drn++;
            end
            if (prev == PH_COLLECT && iv) begin
                m_acc++;
                if (mq.size() < DEPTH) begin
                    w   = e;
                    w.d = relu_exp(e.d);
                    mq.push_back(w);
                end else begin
                    m_ovf = 1'b1;
                    m_drn++;
                end
                if (m_acc == TOTAL) m_phase = PH_FLUSH;
            end
            if (prev == PH_FLUSH && m_drn == TOTAL) begin
                m_phase = PH_IDLE;
                m_fd    = 1'b1;
            end
            if (mq.size() > 0) m_head = mq[0];
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"},   busy,          m_phase != PH_IDLE);
        chk({tag, ".done"},   frame_done,    m_fd);
        chk({tag, ".ovf"},    overflow,      m_ovf);
        chk({tag, ".level"},  level,         mq.size());
        chk({tag, ".stall"},  bus.stall,     mq.size() >= DEPTH - 2);
        chk({tag, ".valid"},  bus.out_valid, mq.size() > 0);
        chk({tag, ".data"},   bus.out_data,  m_head.d);
        chk({tag, ".x"},      bus.out_x,     m_head.x);
        chk({tag, ".y"},      bus.out_y,     m_head.y);
        chk({tag, ".ch"},     bus.out_ch,    m_head.ch);
    endtask

    task automatic apply(input bit st, iv, input ent_t e, input bit rdy);
        start         = st;
        bus.in_valid  = iv;
        bus.in_data   = e.d;
        bus.in_x      = e.x;
        bus.in_y      = e.y;
        bus.in_ch     = e.ch;
        bus.out_ready = rdy;
        @(posedge clk);
        model_step(st, iv, e, rdy);
        #1;
    endtask

    vec_t        tbl[23];
    logic [31:0] fl_heads[7] = '{32'd104, 32'd105, 32'd106, 32'd107, 32'd108, 32'd110, 32'd111};
    logic [31:0] vals[TOTAL] = '{32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF, 32'd5, 32'hFFFF_FFFD, 32'd7,
                                32'd9, 32'h8000_0000, 32'd1, 32'd2, 32'd3, 32'd4};

    initial begin
        int  pushed, pops;
        bit  seen_fd;
        bit  iv, rdy, st;

        // Backpressure, full push+pop, drop, ignored push in flush, drain and done.
        tbl[0] = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 1; i <= 8; i++)
            tbl[i] = v(0, 1, 32'(99 + i), 0, i, 1, 100, i >= 6, 0, 1, 0);
        tbl[9]  = v(0, 1, 108, 1, 8, 1, 101, 1, 0, 1, 0);
        tbl[10] = v(0, 1, 109, 0, 8, 1, 101, 1, 1, 1, 0);
        tbl[11] = v(0, 1, 110, 1, 8, 1, 102, 1, 1, 1, 0);
        tbl[12] = v(0, 1, 111, 1, 8, 1, 103, 1, 1, 1, 0);
        tbl[13] = v(0, 1, 999, 0, 8, 1, 103, 1, 1, 1, 0);
        for (int k = 0; k < 7; k++)
            tbl[14 + k] = v(0, 0, 0, 1, 7 - k, 1, fl_heads[k], (7 - k) >= 6, 1, 1, 0);
        tbl[21] = v(0, 0, 0, 1, 0, 0, 111, 0, 1, 0, 1);
        tbl[22] = v(0, 1, 55, 1, 0, 0, 111, 0, 1, 0, 0);

        arst_n_in     = 1'b1;
        start         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_x      = '0;
        bus.in_y      = '0;
        bus.in_ch     = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #2 arst_n_in = 1'b0;
        #10;
        check_model("reset");
        @(posedge clk);
        #1 arst_n_in = 1'b1;

        for (int i = 0; i < 23; i++) begin
            apply(tbl[i].st, tbl[i].iv, mk(tbl[i].d), tbl[i].rdy);
            chk($sformatf("tbl%0d.level", i), level,         tbl[i].lvl);
            chk($sformatf("tbl%0d.valid", i), bus.out_valid, tbl[i].vld);
            chk($sformatf("tbl%0d.data", i),  bus.out_data,  tbl[i].hd);
            chk($sformatf("tbl%0d.stall", i), bus.stall,     tbl[i].stl);
            chk($sformatf("tbl%0d.ovf", i),   overflow,      tbl[i].ovf);
            chk($sformatf("tbl%0d.busy", i),  busy,          tbl[i].bsy);
            chk($sformatf("tbl%0d.done", i),  frame_done,    tbl[i].fd);
        end

        // Basic frame with streaming drain and ReLU-sensitive values.
        apply(1, 0, mk(0), 1);
        chk("basic.ovf_cleared", overflow, 0);
        for (int i = 0; i < TOTAL; i++) begin
            apply(0, 1, mk(vals[i]), 1);
            chk($sformatf("basic%0d.valid", i), bus.out_valid, 1);
            chk($sformatf("basic%0d.data", i),  bus.out_data,  relu_exp(vals[i]));
            chk($sformatf("basic%0d.level", i), level,         1);
            check_model($sformatf("basic%0d", i));
        end
        apply(0, 0, mk(0), 1);
        chk("basic.done_pulse", frame_done, 1);
        chk("basic.busy_low", busy, 0);
        apply(0, 0, mk(0), 1);
        chk("basic.done_single", frame_done, 0);

        // Push in IDLE is discarded; start during COLLECT does not clear the FIFO.
        apply(0, 1, mk(32'd77), 0);
        chk("idle_push.level", level, 0);
        apply(1, 0, mk(0), 0);
        apply(0, 1, mk(32'd1), 0);
        apply(0, 1, mk(32'd2), 0);
        apply(1, 0, mk(0), 0);
        chk("start_ignored.level", level, 2);
        chk("start_ignored.busy", busy, 1);
        check_model("start_ignored");

        // Asynchronous reset after 3 of the frame's pushes.
        apply(0, 1, mk(32'd3), 0);
        #3 arst_n_in = 1'b0;
        model_reset();
        #1;
        check_model("midreset");
        @(posedge clk);
        #1 arst_n_in = 1'b1;

        apply(1, 0, mk(0), 0);
        pushed  = 0;
        pops    = 0;
        seen_fd = 1'b0;
        for (int c = 0; c < 300 && !seen_fd; c++) begin
            iv  = (pushed < TOTAL) && !bus.stall && ($urandom_range(0, 1) == 1);
            rdy = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && rdy) pops++;
            if (iv) pushed++;
            apply(0, iv, mk($urandom), rdy);
            check_model("refill");
            if (frame_done) seen_fd = 1'b1;
        end
        chk("refill.done_seen", seen_fd, 1);
        chk("refill.pops_at_done", pops, TOTAL);

        // Randomized traffic: frames, stray starts, overflow and backpressure.
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(0, 9) == 0);
            iv  = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 4);
            apply(st, iv, mk($urandom), rdy);
            check_model("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/output_collector.md
# output_collector

Downstream stage of the convolution controller and datapath. Captures each finished output pixel (accumulator value plus its x/y/output-channel coordinates) when the upstream `output_valid` strobe fires. Buffers it in a small FIFO and drains it to the host over a valid/ready handshake. Tracks frame completion and raises `stall` early enough for the controller's two-cycle output pipeline to be absorbed without loss.

## Interface
Parameters:
- `ACC_WIDTH`, 32: accumulator/output data width (signed).
- `COORD_WIDTH`, 32: width of each x/y/ch coordinate.
- `DEPTH`, 8: FIFO entries; power of two, ≥4.
- `TOTAL_OUTPUTS`, 1024*1024*64: outputs per frame (width × height × output channels).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `arst_n_in`  in  1  reset, asynchronous, active-low.
- `start`  in  1  pulse: begin a new frame.
- `busy`  out  1  high in COLLECT or FLUSH.
- `frame_done`  out  1  one-cycle pulse when the last frame output leaves the FIFO.
- `in_valid`  in  1  upstream output strobe.
- `in_data`  in  ACC_WIDTH  accumulator value.
- `in_x`, `in_y`, `in_ch`  in  COORD_WIDTH each  coordinates of `in_data`.
- `stall`  out  1  almost-full; the controller must stop issuing MACs.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  host accepts the head entry.
- `out_data`  out  ACC_WIDTH  head data.
- `out_x`, `out_y`, `out_ch`  out  COORD_WIDTH each  head coordinates.
- `overflow`  out  1  sticky: an entry was dropped.
- `level`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- FSM states and transitions:
  - IDLE → COLLECT on `start`.
  - COLLECT → FLUSH when accepted-count reaches `TOTAL_OUTPUTS`.
  - FLUSH → IDLE when drained-count reaches `TOTAL_OUTPUTS`; `frame_done` pulses in the same cycle.
- `start` outside IDLE is ignored.
- Entering COLLECT clears `overflow`, both frame counters and the FIFO.
- Push: `in_valid` in COLLECT only.
  - `in_valid` in IDLE or FLUSH is discarded and not counted; `overflow` is not set.
- Pop: `out_valid && out_ready`, in any state.
- Full FIFO with simultaneous push and pop: both succeed and `level` is unchanged.
- Full FIFO with push and no pop: entry dropped, `overflow` set, accepted-count still increments so frame termination is preserved.
- Empty FIFO: `out_valid`=0; `out_ready` is ignored.
- `stall` = `level ≥ DEPTH-2`. This margin covers the two registered cycles between a controller MAC and its `output_valid`.
- Pointers wrap modulo DEPTH. Counters are 64-bit and do not wrap within a frame.
- Outputs while `out_valid`=0 hold their last head values. Consumers must not sample them.

## Timing
- Reset values: FSM=IDLE; `busy`=0, `frame_done`=0, `stall`=0, `out_valid`=0, `overflow`=0, `level`=0; `out_data`/`out_x`/`out_y`/`out_ch`=0.
- Latency: entry pushed at edge N appears at the head with `out_valid`=1 after edge N (visible in cycle N+1) when the FIFO was empty. There is no combinational in→out path.
- Head is show-ahead: pop at edge N exposes the next entry in cycle N+1.
- `level`, `stall` and `overflow` are registered and update on the push/pop edge.
- `frame_done` is registered and asserted exactly one cycle. `busy` falls in the same cycle.
- Asynchronous reset mid-frame returns to IDLE immediately, empties the FIFO, and discards any partial frame.

## Configuration
- `OUTPUT_COLLECTOR_RELU_EN` defined: at push, a negative `in_data` (MSB=1) is stored as 0. Coordinates are unaffected.
- Undefined: `in_data` is stored unmodified.
- The macro affects data only, never handshakes or counts.

## Structure
- Shared package `output_collector_pkg` holds:
  - `collector_state_t` (IDLE, COLLECT, FLUSH).
  - `output_entry_t` packed struct {data, x, y, ch}.
- Sub-module `output_fifo`: generic show-ahead synchronous FIFO of `output_entry_t`. It has push/pop/full/empty/level ports and contains the wrap and simultaneous push/pop logic.
- The top level holds the FSM, counters, ReLU, `stall` and `overflow`.

## Test plan
- Basic frame: `TOTAL_OUTPUTS`=4, `start`, push data 5,-3,7,9 with `out_ready`=1 → four pops in order, `out_valid` one cycle after each push, `frame_done` single pulse after the 4th pop, `busy`=0 after.
- Backpressure: `DEPTH`=8, `out_ready`=0, push 6 → `stall`=1 at `level`=6; push 2 more → `level`=8, `overflow`=0. Push a 9th → `overflow`=1 and the entry is dropped.
- Full simultaneous: `level`=8, push and pop in the same cycle → `level` stays 8, `overflow` stays 0, FIFO order intact.
- ReLU: push -1, 0, 2147483647 → with `OUTPUT_COLLECTOR_RELU_EN` reads 0, 0, 2147483647; without it reads -1, 0, 2147483647.
- Ignore outside frame: `in_valid` in IDLE → `level`=0 and no counting. `start` during COLLECT → no state change.
- Reset mid-frame: after 3 of 8 pushes, pulse `arst_n_in` low → all outputs at reset values. A new `start` then collects 8 from scratch with `frame_done` on the 8th pop.
